// File: rtl/pio_pkg.sv
// Shared widths, slot layout and error-bit indices for the PIO read completion path.
package pio_pkg;

   localparam int RID_TAG_W       = 24;
   localparam int PIO_ADDR_W      = 13;
   localparam int PIO_DATA_W      = 64;
   localparam int LOWER_ADDR_W    = 4;
   localparam int ERR_W           = 2;
   localparam int TMO_CNT_W       = 16;

   localparam int ERR_OVERFLOW    = 0;
   localparam int ERR_UNSOLICITED = 1;

   typedef struct packed {
      logic [RID_TAG_W-1:0]    rid_tag;
      logic [LOWER_ADDR_W-1:0] lower_addr;
      logic [PIO_DATA_W-1:0]   data;
   } slot_t;

endpackage

// File: rtl/pio_read_tracker_if.sv
// PIO read request / user register / completion signal bundle.
// slave is the tracker's view, master is the surrounding logic's view.
interface pio_read_tracker_if;
   import pio_pkg::*;

   logic                    read_valid;
   logic [PIO_ADDR_W-1:0]   read_address;
   logic [RID_TAG_W-1:0]    read_rid_tag;

   logic                    user_read_valid;
   logic [PIO_ADDR_W-1:0]   user_read_address;
   logic [PIO_DATA_W-1:0]   user_read_data;
   logic                    user_read_data_valid;

   logic                    cpl_valid;
   logic                    cpl_ready;
   logic [RID_TAG_W-1:0]    cpl_rid_tag;
   logic [LOWER_ADDR_W-1:0] cpl_lower_addr;
   logic [PIO_DATA_W-1:0]   cpl_data;

   logic [ERR_W-1:0]        error;
   logic [TMO_CNT_W-1:0]    timeout_count;

   modport slave (
      input  read_valid, read_address, read_rid_tag,
      output user_read_valid, user_read_address,
      input  user_read_data, user_read_data_valid,
      output cpl_valid, cpl_rid_tag, cpl_lower_addr, cpl_data,
      input  cpl_ready,
      output error, timeout_count
   );

   modport master (
      output read_valid, read_address, read_rid_tag,
      input  user_read_valid, user_read_address,
      output user_read_data, user_read_data_valid,
      input  cpl_valid, cpl_rid_tag, cpl_lower_addr, cpl_data,
      output cpl_ready,
      input  error, timeout_count
   );

endinterface

// File: rtl/pio_read_tracker.sv
// Tracks outstanding PIO reads, forwards them to user logic one cycle later and returns
// in-order completions; cpl_valid/cpl_ready stalls only the head, timeouts fill silent reads.
module pio_read_tracker
   import pio_pkg::*;
#(
   parameter int                    DEPTH        = 4,
   parameter int                    TIMEOUT      = 1024,
   parameter logic [PIO_DATA_W-1:0] TIMEOUT_DATA = 64'hFFFF_FFFF_FFFF_FFFF
) (
   input  logic               clock,
   input  logic               reset,
   pio_read_tracker_if.slave  bus
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;

   typedef logic [PTR_W-1:0] ptr_t;
   typedef logic [IDX_W-1:0] idx_t;

   slot_t                slot_q [DEPTH];
   logic [DEPTH-1:0]     slot_filled;
   ptr_t                 wr_ptr;
   ptr_t                 fill_ptr;
   ptr_t                 rd_ptr;
   logic [TMO_CNT_W-1:0] wait_cnt;

   ptr_t                 occupancy;
   idx_t                 wr_idx;
   idx_t                 fill_idx;
   idx_t                 head_idx;
   logic                 full;
   logic                 push;
   logic                 pending;
   logic                 data_fill;
   logic                 timed_out;
   logic                 pop;
   logic                 cpl_vld;

   assign occupancy = wr_ptr - rd_ptr;
   assign wr_idx    = wr_ptr[IDX_W-1:0];
   assign fill_idx  = fill_ptr[IDX_W-1:0];
   assign head_idx  = rd_ptr[IDX_W-1:0];

   // full uses the pre-pop occupancy, so a push never rides on a same-cycle pop
   assign full      = (occupancy == ptr_t'(DEPTH));
   assign push      = bus.read_valid && !full;
   assign pending   = (fill_ptr != wr_ptr);
   assign data_fill = bus.user_read_data_valid && pending;
   assign timed_out = pending && !bus.user_read_data_valid
                      && (wait_cnt == TMO_CNT_W'(TIMEOUT - 1));

   assign cpl_vld   = (occupancy != '0) && slot_filled[head_idx];
   assign pop       = cpl_vld && bus.cpl_ready;

   assign bus.cpl_valid      = cpl_vld;
   assign bus.cpl_rid_tag    = slot_q[head_idx].rid_tag;
   assign bus.cpl_lower_addr = slot_q[head_idx].lower_addr;
   assign bus.cpl_data       = slot_q[head_idx].data;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            slot_q[i] <= '0;
         end
         slot_filled           <= '0;
         wr_ptr                <= '0;
         fill_ptr              <= '0;
         rd_ptr                <= '0;
         wait_cnt              <= '0;
         bus.user_read_valid   <= 1'b0;
         bus.user_read_address <= '0;
         bus.error             <= '0;
         bus.timeout_count     <= '0;
      end else begin
         // pop, push and fill always address distinct slots, so their order here is free
         if (pop) begin
            slot_q[head_idx]      <= '0;
            slot_filled[head_idx] <= 1'b0;
            rd_ptr                <= rd_ptr + 1'b1;
         end

         bus.user_read_valid <= push;
         if (push) begin
            slot_q[wr_idx]        <= '{rid_tag:    bus.read_rid_tag,
                                       lower_addr: bus.read_address[LOWER_ADDR_W-1:0],
                                       data:       '0};
            slot_filled[wr_idx]   <= 1'b0;
            wr_ptr                <= wr_ptr + 1'b1;
            bus.user_read_address <= bus.read_address;
         end else if (bus.read_valid) begin
            bus.error[ERR_OVERFLOW] <= 1'b1;
         end

         if (data_fill || timed_out) begin
            slot_q[fill_idx].data <= data_fill ? bus.user_read_data : TIMEOUT_DATA;
            slot_filled[fill_idx] <= 1'b1;
            fill_ptr              <= fill_ptr + 1'b1;
         end

         if (bus.user_read_data_valid && !pending) begin
            bus.error[ERR_UNSOLICITED] <= 1'b1;
         end

         if (!pending || bus.user_read_data_valid || timed_out) begin
            wait_cnt <= '0;
         end else begin
            wait_cnt <= wait_cnt + 1'b1;
         end

         if (timed_out && (bus.timeout_count != '1)) begin
            bus.timeout_count <= bus.timeout_count + 1'b1;
         end
      end
   end

endmodule
